// File: rtl/te_window_sched_if.sv
// ---------------------------------------------------------------------------
// te_window_sched_if
// Stream bundle between a raster pixel source, the 3x3 window sequencer and
// the downstream window consumer.
//   s_pixel  [7:0]  raster pixel from the source
//   s_valid         source pixel valid
//   s_ready         sequencer can take a pixel
//   m_window [71:0] packed 3x3 window, in1 = [7:0] ... in9 = [71:64]
//   m_valid         window valid
//   m_ready         consumer takes the window
// Modports:
//   slave  - the sequencer (consumes pixels, produces windows)
//   master - the environment (produces pixels, consumes windows)
// ---------------------------------------------------------------------------
interface te_window_sched_if;
   logic [7:0]  s_pixel;
   logic        s_valid;
   logic        s_ready;
   logic [71:0] m_window;
   logic        m_valid;
   logic        m_ready;

   modport slave (
      input  s_pixel,
      input  s_valid,
      input  m_ready,
      output s_ready,
      output m_window,
      output m_valid
   );

   modport master (
      output s_pixel,
      output s_valid,
      output m_ready,
      input  s_ready,
      input  m_window,
      input  m_valid
   );
endinterface

// File: rtl/te_window_sched.sv
// ---------------------------------------------------------------------------
// te_window_sched
// Window sequencer for the 3x3 edge-preserving filters in the transmission-
// estimate path. Takes a raster 8-bit pixel stream, keeps two line buffers
// and a 3x3 column-shift window, and emits one packed window per interior
// pixel (output image is (IMG_W-2) x (IMG_H-2) windows).
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   start       one-cycle pulse, starts a frame from IDLE, ignored elsewhere
//   bus         te_window_sched_if.slave: pixel in (s_*), window out (m_*)
//   busy        high in FILL, STREAM and DRAIN
//   frame_done  one-cycle pulse after the last window of a frame is taken
// ---------------------------------------------------------------------------
module te_window_sched #(
   parameter int IMG_W = 320,
   parameter int IMG_H = 240,
   parameter int CW    = 9,
   parameter int RW    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   te_window_sched_if.slave bus,
   output logic             busy,
   output logic             frame_done
);

   localparam int PIX_W = 8;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [CW-1:0] COL_ONE  = CW'(1);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FILL   = 2'd1,
      S_STREAM = 2'd2,
      S_DRAIN  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      col_q, col_d;
   logic [RW-1:0]      row_q, row_d;
   logic [9*PIX_W-1:0] win_q, win_d;
   logic [9*PIX_W-1:0] m_window_q, m_window_d;
   logic               m_valid_q, m_valid_d;
   logic               frame_done_q, frame_done_d;

   // lb1 holds the line two rows above the incoming pixel, lb0 the line
   // directly above it. Contents are never reset: rows 0 and 1 of each
   // frame overwrite every entry before any window is emitted.
   logic [PIX_W-1:0]   lb0_q [IMG_W];
   logic [PIX_W-1:0]   lb1_q [IMG_W];

   logic [PIX_W-1:0]   top, mid;
   logic               in_frame;
   logic               s_ready;
   logic               accept;
   logic               win_take;
   logic               emit;
   logic               col_last;
   logic               row_last;

   // ------------------------------------------------------------------
   // Handshakes
   // ------------------------------------------------------------------
   // The output register can be refilled in the same cycle it is drained,
   // so a pixel is taken whenever the window slot is free or being freed.
   assign in_frame    = (state_q == S_FILL) || (state_q == S_STREAM);
   assign s_ready     = in_frame && (!m_valid_q || bus.m_ready);
   assign accept      = bus.s_valid && s_ready;
   assign win_take    = m_valid_q && bus.m_ready;

   assign col_last    = (col_q == COL_LAST);
   assign row_last    = (row_q == ROW_LAST);

   // Only pixels at row >= 2, col >= 2 complete a window whose three
   // columns all belong to the current line triple; columns left over from
   // the previous line are shifted out during col 0 and col 1.
   assign emit        = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO);

   assign top         = lb1_q[col_q];
   assign mid         = lb0_q[col_q];

   // ------------------------------------------------------------------
   // Window shift: columns move left, new right column is {top, mid, p}
   // ------------------------------------------------------------------
   always_comb begin
      win_d = win_q;
      if (accept) begin
         win_d[ 7: 0] = win_q[15: 8];
         win_d[15: 8] = win_q[23:16];
         win_d[23:16] = top;
         win_d[31:24] = win_q[39:32];
         win_d[39:32] = win_q[47:40];
         win_d[47:40] = mid;
         win_d[55:48] = win_q[63:56];
         win_d[63:56] = win_q[71:64];
         win_d[71:64] = bus.s_pixel;
      end
   end

   // ------------------------------------------------------------------
   // Raster position counters
   // ------------------------------------------------------------------
   // Wrapping at the last pixel of the frame leaves row = col = 0 for the
   // next frame without a separate clear on start.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (accept) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : (row_q + ROW_ONE);
         end else begin
            col_d = col_q + COL_ONE;
         end
      end
   end

   // ------------------------------------------------------------------
   // Output window register
   // ------------------------------------------------------------------
   // emit can only happen when the slot is free or being taken, so loading
   // a new window never overwrites one the consumer has not seen.
   always_comb begin
      m_valid_d  = m_valid_q;
      m_window_d = m_window_q;
      if (emit) begin
         m_valid_d  = 1'b1;
         m_window_d = win_d;
      end else if (win_take) begin
         m_valid_d  = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Frame state machine
   // ------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      frame_done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FILL;
            end
         end
         S_FILL: begin
            if (accept && (row_q == ROW_ONE) && col_last) begin
               state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            if (accept && row_last && col_last) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // The last pixel of a frame always emits, so m_valid is set
            // here until the final window is taken.
            if (win_take) begin
               state_d      = S_IDLE;
               frame_done_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         col_q        <= '0;
         row_q        <= '0;
         win_q        <= '0;
         m_window_q   <= '0;
         m_valid_q    <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         win_q        <= win_d;
         m_window_q   <= m_window_d;
         m_valid_q    <= m_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Line buffers: the line above moves up one slot as the new pixel
   // lands in its column.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1_q[col_q] <= mid;
         lb0_q[col_q] <= bus.s_pixel;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.s_ready  = s_ready;
   assign bus.m_valid  = m_valid_q;
   assign bus.m_window = m_window_q;
   assign busy         = (state_q != S_IDLE);
   assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_te_window_sched.sv
// ---------------------------------------------------------------------------
// tb_te_window_sched
// Bench for te_window_sched with a 5x4 image. A frame-level model keeps the
// accepted pixels as an image and derives every window from its 3x3
// neighbourhood; expected windows wait in a queue until the consumer takes
// them. Literal expectations pin the index-pattern frames.
// ---------------------------------------------------------------------------
module tb_te_window_sched;
   localparam int W    = 5;
   localparam int H    = 4;
   localparam int NPIX = W * H;
   localparam logic [71:0] FIRST_WIN = 72'h0C_0B_0A_07_06_05_02_01_00;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic busy;
   logic frame_done;

   te_window_sched_if bus ();

   te_window_sched #(
      .IMG_W (W),
      .IMG_H (H),
      .CW    (3),
      .RW    (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .bus        (bus),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // 5-tap P1 sum: 4*centre + north + west + east + south
   function automatic int p1(input logic [71:0] w);
      return 4 * int'(w[39:32]) + int'(w[15:8]) + int'(w[31:24]) +
             int'(w[47:40]) + int'(w[63:56]);
   endfunction

   // ---------------- frame-level model ----------------
   logic [7:0]  img [NPIX];
   logic [71:0] exp_q [$];
   logic [71:0] acc_win [$];
   bit          active;
   int          pa;
   bit          fd_next;
   int          fd_cnt;
   int          cyc_n;
   int          last_acc_cyc;
   int          fd_cyc;
   bit          take_start;
   bit          fin;
   int          r_m, c_m;

   function automatic logic [71:0] model_win(input int r, input int c);
      logic [71:0] w;
      w = '0;
      for (int dr = 0; dr < 3; dr++)
         for (int dc = 0; dc < 3; dc++)
            w[8*(3*dr+dc) +: 8] = img[(r - 2 + dr) * W + (c - 2 + dc)];
      return w;
   endfunction

   always @(negedge clk) begin
      cyc_n++;
      if (rst) begin
         exp_q.delete();
         active  = 1'b0;
         pa      = 0;
         fd_next = 1'b0;
         chk("rst_m_valid", bus.m_valid, 0);
         chk("rst_m_window", bus.m_window, 0);
         chk("rst_s_ready", bus.s_ready, 0);
         chk("rst_busy", busy, 0);
         chk("rst_frame_done", frame_done, 0);
      end else begin
         chk("m_valid", bus.m_valid, exp_q.size() != 0);
         if (exp_q.size() != 0) begin
            chk("m_window", bus.m_window, exp_q[0]);
            chk("p1_sum", p1(bus.m_window), p1(exp_q[0]));
         end
         chk("s_ready", bus.s_ready,
             active && (pa < NPIX) && (exp_q.size() == 0 || bus.m_ready));
         chk("busy", busy, active);
         chk("frame_done", frame_done, fd_next);
         if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc_n;
         end
         // advance the model to what the next clock edge does
         take_start = start && !active;
         fd_next    = 1'b0;
         if (bus.m_valid && bus.m_ready) begin
            acc_win.push_back(bus.m_window);
            last_acc_cyc = cyc_n;
            fin = (pa == NPIX) && (exp_q.size() == 1);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (fin) begin
               fd_next = 1'b1;
               active  = 1'b0;
            end
         end
         if (bus.s_valid && bus.s_ready && pa < NPIX) begin
            img[pa] = bus.s_pixel;
            r_m = pa / W;
            c_m = pa % W;
            if (r_m >= 2 && c_m >= 2) exp_q.push_back(model_win(r_m, c_m));
            pa++;
         end
         if (take_start) begin
            active = 1'b1;
            pa     = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic run_frame(input int mode, input int bp, input int stop_at, input bit mid_start);
      int          idx      = 0;
      int          guard    = 0;
      int          bp_left  = 0;
      bit          bp_armed = (bp > 0);
      int          fd0      = fd_cnt;
      logic [7:0]  pix [NPIX];
      for (int i = 0; i < NPIX; i++) pix[i] = (mode == 0) ? 8'(i) : 8'($urandom);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (idx < stop_at && guard < 1000) begin
         bus.s_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         bus.s_pixel = pix[idx];
         if (bp_armed && bus.m_valid) begin
            bp_left  = bp;
            bp_armed = 1'b0;
         end
         if (bp_left > 0) begin
            bus.m_ready = 1'b0;
            bp_left--;
         end else begin
            bus.m_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
         end
         start = mid_start && (idx == NPIX / 2);
         @(negedge clk);
         if (bp > 0 && !bus.m_ready && bus.m_valid) begin
            chk("bp_hold_window", bus.m_window, FIRST_WIN);
            chk("bp_s_ready", bus.s_ready, 0);
         end
         if (bus.s_valid && bus.s_ready) idx++;
         @(posedge clk); #1;
         guard++;
      end
      start = 1'b0;
      chk("feed_timeout", guard < 1000, 1);
      if (stop_at < NPIX) return;
      guard = 0;
      while (fd_cnt == fd0 && guard < 200) begin
         bus.s_valid = 1'($urandom_range(0, 1));
         bus.s_pixel = 8'($urandom);
         bus.m_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         guard++;
      end
      bus.s_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("frame_done_timeout", fd_cnt == fd0, 0);
      chk("frame_done_once", fd_cnt - fd0, 1);
      chk("frame_done_latency", fd_cyc - last_acc_cyc, 1);
   endtask

   task automatic check_index_frame(input string tag, input int base);
      int cen [6] = '{6, 7, 8, 11, 12, 13};
      chk({tag, "_nwin"}, acc_win.size() - base, 6);
      if (acc_win.size() > base) chk({tag, "_first"}, acc_win[base], FIRST_WIN);
      for (int i = 0; i < 6 && base + i < acc_win.size(); i++)
         chk({tag, "_centre"}, acc_win[base + i][39:32], cen[i]);
   endtask

   initial begin
      int base;
      int fd_before;
      rst         = 1'b1;
      start       = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_pixel = 8'h00;
      bus.m_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // s_valid in IDLE must not be taken
      bus.s_valid = 1'b1;
      bus.s_pixel = 8'hAA;
      bus.m_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_s_ready", bus.s_ready, 0);
         chk("idle_busy", busy, 0);
         @(posedge clk); #1;
      end

      // index frame, free-running consumer
      base = acc_win.size();
      run_frame(0, 0, NPIX, 1'b0);
      check_index_frame("fill", base);
      chk("idle_after_frame_busy", busy, 0);

      // index frame with 4 cycles of backpressure on the first window
      base = acc_win.size();
      run_frame(0, 4, NPIX, 1'b0);
      check_index_frame("bp", base);

      // reset after pixel 9, then a clean frame
      fd_before = fd_cnt;
      run_frame(0, 0, 10, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("abort_no_frame_done", fd_cnt, fd_before);
      base = acc_win.size();
      run_frame(0, 0, NPIX, 1'b0);
      check_index_frame("post_rst", base);

      // bursty random frames, some with start pulsed mid-stream
      for (int f = 0; f < 8; f++) run_frame(1, 0, NPIX, f[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
